// File: rtl/signed_mult8x8_cpa_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_pkg
//  Brief    : Shared widths and row/tag types for the signed 8x8 CPA pipeline.
//  Revision : 1.0
// ============================================================================
package mult_pkg;

  localparam int PP_W  = 16;
  localparam int SPLIT = 8;
  localparam int TAG_W = 4;

  typedef logic [PP_W-1:0]  pp_row_t;
  typedef logic [TAG_W-1:0] tag_t;

endpackage
`default_nettype wire

// File: rtl/signed_mult8x8_cpa_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : signed_mult8x8_cpa_pipe_if
//  Brief    : Operand/result handshake bundle between Wallace tree, CPA and FMA.
//  Revision : 1.0
// ============================================================================
interface signed_mult8x8_cpa_pipe_if;
  import mult_pkg::*;

  logic    flush;
  logic    in_valid;
  logic    in_ready;
  pp_row_t pp0;
  pp_row_t pp1;
  tag_t    in_tag;
  logic    out_valid;
  logic    out_ready;
  pp_row_t product;
  tag_t    out_tag;

  modport master (
    output flush, in_valid, pp0, pp1, in_tag, out_ready,
    input  in_ready, out_valid, product, out_tag
  );

  modport slave (
    input  flush, in_valid, pp0, pp1, in_tag, out_ready,
    output in_ready, out_valid, product, out_tag
  );

endinterface
`default_nettype wire

// File: rtl/signed_mult8x8_cpa_pipe_cpa_slice.sv
`default_nettype none
// ============================================================================
//  Module   : cpa_slice
//  Brief    : Combinational W-bit ripple adder slice with carry in and out.
//  Revision : 1.0
// ============================================================================
module cpa_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule
`default_nettype wire

// File: rtl/signed_mult8x8_cpa_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : signed_mult8x8_cpa_pipe
//  Brief    : Two-stage valid/ready carry-propagate adder merging the Wallace
//             tree's carry-save rows into the final 16-bit signed product.
//  Revision : 1.0
// ============================================================================
module signed_mult8x8_cpa_pipe
  import mult_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  signed_mult8x8_cpa_pipe_if.slave        bus
);

  localparam int HI_W = PP_W - SPLIT;

  logic             live;
  logic             s1_valid;
  logic             s2_valid;
  logic             s1_adv;
  logic             s2_adv;
  logic             in_ready;

  logic [SPLIT-1:0] s1_sum_lo;
  logic             s1_c1;
  logic [HI_W-1:0]  s1_pp0_hi;
  logic [HI_W-1:0]  s1_pp1_hi;
  tag_t             s1_tag;

  logic [SPLIT-1:0] lo_sum;
  logic             lo_cout;
  logic [HI_W-1:0]  hi_sum;
  // Tree rows are already sign-extended, so the MSB carry carries no information.
  logic             unused_msb_carry;

  pp_row_t          prod_reg;
  tag_t             tag_reg;

  cpa_slice #(.W(SPLIT)) u_lo_slice (
    .a    (bus.pp0[SPLIT-1:0]),
    .b    (bus.pp1[SPLIT-1:0]),
    .cin  (1'b0),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  cpa_slice #(.W(HI_W)) u_hi_slice (
    .a    (s1_pp0_hi),
    .b    (s1_pp1_hi),
    .cin  (s1_c1),
    .sum  (hi_sum),
    .cout (unused_msb_carry)
  );

  // live keeps in_ready low until the first edge after reset release.
  always_comb begin
    s2_adv   = s1_valid && (!s2_valid || bus.out_ready);
    in_ready = live && (bus.flush || !s1_valid || s2_adv);
    s1_adv   = bus.in_valid && in_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live     <= 1'b0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      live <= 1'b1;
      if (bus.flush) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        if (s1_adv) begin
          s1_valid <= 1'b1;
        end else if (s2_adv) begin
          s1_valid <= 1'b0;
        end
        if (s2_adv) begin
          s2_valid <= 1'b1;
        end else if (bus.out_ready) begin
          s2_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s1_adv) begin
      s1_sum_lo <= lo_sum;
      s1_c1     <= lo_cout;
      s1_pp0_hi <= bus.pp0[PP_W-1:SPLIT];
      s1_pp1_hi <= bus.pp1[PP_W-1:SPLIT];
      s1_tag    <= bus.in_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_reg <= '0;
      tag_reg  <= '0;
    end else if (s2_adv) begin
      prod_reg <= {hi_sum, s1_sum_lo};
      tag_reg  <= s1_tag;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.product   = prod_reg;
  assign bus.out_tag   = tag_reg;

endmodule
`default_nettype wire

// File: tb/tb_signed_mult8x8_cpa_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_signed_mult8x8_cpa_pipe
//  Brief    : Scoreboard bench for the signed 8x8 CPA pipeline.
//  Revision : 1.0
// ============================================================================
module tb_signed_mult8x8_cpa_pipe;
  import mult_pkg::*;

  typedef struct packed {
    pp_row_t prod;
    tag_t    tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  signed_mult8x8_cpa_pipe_if bus ();

  signed_mult8x8_cpa_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   outs   = 0;
  int   outs_mark;
  bit   stream_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge when both are high here.
  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      outs++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: product %h tag %h with nothing expected",
                 bus.product, bus.out_tag);
      end else begin
        mon_e = exp_q.pop_front();
        chk("product", {16'h0, bus.product}, {16'h0, mon_e.prod});
        chk("out_tag", {28'h0, bus.out_tag}, {28'h0, mon_e.tag});
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input pp_row_t a, input pp_row_t b, input tag_t t, input pp_row_t exp);
    bit ok;
    ok           = 1'b0;
    bus.in_valid = 1'b1;
    bus.pp0      = a;
    bus.pp1      = b;
    bus.in_tag   = t;
    for (int w = 0; w < 200 && !ok; w++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) ok = 1'b1;
    end
    if (ok) begin
      exp_q.push_back('{prod: exp, tag: t});
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: tag %0h not accepted, in_ready %b required 1", t, bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int w = 0; w < 200 && exp_q.size() != 0; w++) @(posedge clk);
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pp_row_t ra, rb;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.pp0       = '0;
    bus.pp1       = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'h0, bus.out_valid}, 0);
    chk("rst_product",   {16'h0, bus.product}, 0);
    chk("rst_out_tag",   {28'h0, bus.out_tag}, 0);
    chk("rst_in_ready",  {31'h0, bus.in_ready}, 0);
    rst = 1'b0;
    #1;
    chk("in_ready_before_edge", {31'h0, bus.in_ready}, 0);
    @(posedge clk);
    #1;
    chk("in_ready_after_edge", {31'h0, bus.in_ready}, 1);

    // Basic sum and two-register latency
    bus.out_ready = 1'b1;
    send(16'h0003, 16'h0004, 4'h1, 16'h0007);
    @(negedge clk);
    chk("lat_stage1", {31'h0, bus.out_valid}, 0);
    @(posedge clk);
    #1;
    chk("lat_stage2", {31'h0, bus.out_valid}, 1);
    drain("drain_basic");

    // Signed result, carry across the split, wrap, high-half carry
    send(16'hFFF0, 16'h0001, 4'h2, 16'hFFF1);
    send(16'h00FF, 16'h0001, 4'h3, 16'h0100);
    send(16'hFFFF, 16'h0001, 4'h4, 16'h0000);
    send(16'h1234, 16'h4321, 4'h5, 16'h5555);
    send(16'h8000, 16'h8000, 4'h6, 16'h0000);
    send(16'h7F80, 16'h0080, 4'h7, 16'h8000);
    drain("drain_directed");

    // Backpressure: two entries fill the pipe, the third waits
    outs_mark     = outs;
    bus.out_ready = 1'b0;
    send(16'h0010, 16'h0001, 4'h1, 16'h0011);
    send(16'h0020, 16'h0002, 4'h2, 16'h0022);
    fork
      send(16'h0030, 16'h0003, 4'h3, 16'h0033);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready",  {31'h0, bus.in_ready}, 0);
          chk("bp_hold_tag",  {28'h0, bus.out_tag}, 1);
          chk("bp_hold_prod", {16'h0, bus.product}, 32'h0011);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain("drain_bp");
    chk("bp_count", outs - outs_mark, 3);

    // Stream with random consumer stalls
    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          ra = pp_row_t'($urandom);
          rb = pp_row_t'($urandom);
          send(ra, rb, tag_t'(i), ra + rb);
        end
        stream_done = 1'b1;
      end
      while (!stream_done) begin
        @(posedge clk);
        #1;
        bus.out_ready = 1'($urandom_range(0, 1));
      end
    join
    bus.out_ready = 1'b1;
    drain("drain_stream");

    // Reset with two entries in flight
    bus.out_ready = 1'b0;
    send(16'h0101, 16'h0001, 4'h8, 16'h0102);
    send(16'h0202, 16'h0002, 4'h9, 16'h0204);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("rstmid_out_valid", {31'h0, bus.out_valid}, 0);
    chk("rstmid_product",   {16'h0, bus.product}, 0);
    chk("rstmid_out_tag",   {28'h0, bus.out_tag}, 0);
    chk("rstmid_in_ready",  {31'h0, bus.in_ready}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rstmid_in_ready_back", {31'h0, bus.in_ready}, 1);
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rstmid_no_stale", {31'h0, bus.out_valid}, 0);
    end
    @(posedge clk);
    #1;
    send(16'h00AA, 16'h0055, 4'hB, 16'h00FF);
    drain("drain_after_rst");

    // Flush with two entries in flight and an input offered in the flush cycle
    bus.out_ready = 1'b0;
    send(16'h0303, 16'h0003, 4'hC, 16'h0306);
    send(16'h0404, 16'h0004, 4'hD, 16'h0408);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.pp0      = 16'h0505;
    bus.pp1      = 16'h0005;
    bus.in_tag   = 4'hE;
    @(negedge clk);
    chk("flush_in_ready", {31'h0, bus.in_ready}, 1);
    @(posedge clk);
    #1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    exp_q.delete();
    bus.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("flush_no_stale", {31'h0, bus.out_valid}, 0);
    end
    @(posedge clk);
    #1;
    send(16'h0101, 16'h0202, 4'hA, 16'h0303);
    drain("drain_after_flush");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
